// File: rtl/img_temporal_diff_pkg.sv
// Shared widths, types and the saturating add used by the temporal difference stage.
package img_temporal_diff_pkg;
    localparam int TD_CH_BITS   = 10;
    localparam int TD_DIFF_BITS = TD_CH_BITS + 1;
    localparam int TD_SUM_BITS  = 32;
    localparam int TD_CNT_BITS  = 20;

    typedef logic signed [TD_DIFF_BITS-1:0] diff_t;
    typedef logic [TD_CH_BITS-1:0]          abs_t;
    typedef logic [TD_SUM_BITS-1:0]         sum_t;
    typedef logic [TD_CNT_BITS-1:0]         cnt_t;

    function automatic sum_t sat_add(sum_t a, abs_t b);
        logic [TD_SUM_BITS:0] s;
        s = {1'b0, a} + (TD_SUM_BITS + 1)'(b);
        return s[TD_SUM_BITS] ? '1 : s[TD_SUM_BITS-1:0];
    endfunction
endpackage

// File: rtl/img_temporal_diff_acc.sv
// Saturating frame accumulator with clear-and-add, add and latch controls.
module img_temporal_diff_acc
    import img_temporal_diff_pkg::*;
#(
    parameter int W    = TD_SUM_BITS,
    parameter int IN_W = TD_CH_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cke_i,
    input  logic            clear_add_i,
    input  logic            add_i,
    input  logic            latch_i,
    input  logic [IN_W-1:0] inc_i,
    output logic [W-1:0]    lat_o
);
    logic [W-1:0] acc_q, acc_d, lat_q, base;
    logic [W:0]   sum;

    always_comb begin
        base  = clear_add_i ? '0 : acc_q;
        sum   = {1'b0, base} + (W + 1)'(inc_i);
        acc_d = acc_q;
        if (clear_add_i || add_i)
            acc_d = sum[W] ? '1 : sum[W-1:0];
    end

    // The latch sees acc_d so the frame-end pixel is part of the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            lat_q <= '0;
        end else if (cke_i) begin
            acc_q <= acc_d;
            if (latch_i)
                lat_q <= acc_d;
        end
    end

    assign lat_o = lat_q;
endmodule

// File: rtl/img_temporal_diff.sv
// Temporal difference, motion flag and per-frame statistics, 2-cycle pipeline.
// Optional max-|diff| position tracking under IMG_TEMPORAL_DIFF_MAXPOS_EN.
module img_temporal_diff
    import img_temporal_diff_pkg::*;
#(
    parameter int CH_BITS   = TD_CH_BITS,
    parameter int DIFF_BITS = CH_BITS + 1,
    parameter int SUM_BITS  = TD_SUM_BITS,
    parameter int CNT_BITS  = TD_CNT_BITS,
    parameter int USER_BITS = 1,
    parameter int COLS_BITS = 10,
    parameter int ROWS_BITS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [CH_BITS-1:0]   param_th,
    input  logic                 s_row_first,
    input  logic                 s_row_last,
    input  logic                 s_col_first,
    input  logic                 s_col_last,
    input  logic                 s_de,
    input  logic [CH_BITS-1:0]   s_cur,
    input  logic [CH_BITS-1:0]   s_prev,
    input  logic [USER_BITS-1:0] s_user,
    input  logic                 s_valid,
    output logic                 m_row_first,
    output logic                 m_row_last,
    output logic                 m_col_first,
    output logic                 m_col_last,
    output logic                 m_de,
    output logic [USER_BITS-1:0] m_user,
    output logic                 m_valid,
    output logic [CH_BITS-1:0]   m_cur,
    output logic [DIFF_BITS-1:0] m_diff,
    output logic                 m_motion,
    output logic [SUM_BITS-1:0]  frame_sad,
    output logic [CNT_BITS-1:0]  frame_motion_cnt,
    output logic                 frame_stat_valid,
`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
    output logic [CH_BITS-1:0]   frame_max_abs,
    output logic [COLS_BITS-1:0] frame_max_x,
    output logic [ROWS_BITS-1:0] frame_max_y,
`endif
    output logic                 frame_first
);
    logic [4:0]           mk0_q, mk1_q;
    logic                 v0_q, v1_q;
    logic [USER_BITS-1:0] user0_q, user1_q;
    logic [CH_BITS-1:0]   cur0_q, cur1_q;
    logic [DIFF_BITS-1:0] diff0_d, diff0_q, diff1_q, neg;
    logic                 mot1_q, first_q, stat_q;
    logic [CH_BITS-1:0]   abs_c, contrib;
    logic                 de0, live, mot_c, sof, eof, add;

    assign diff0_d = DIFF_BITS'({1'b0, s_cur}) - DIFF_BITS'({1'b0, s_prev});

    // mk = {row_first, row_last, col_first, col_last, de}
    assign de0     = mk0_q[0];
    assign neg     = -diff0_q;
    assign abs_c   = CH_BITS'(diff0_q[DIFF_BITS-1] ? neg : diff0_q);
    assign live    = v0_q & de0 & ~first_q;
    assign contrib = live ? abs_c : '0;
    assign mot_c   = live & (abs_c > param_th);
    assign sof     = v0_q & mk0_q[4] & mk0_q[2];
    assign eof     = v0_q & de0 & mk0_q[3] & mk0_q[1];
    assign add     = v0_q & de0;

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q    <= 1'b0;
            mk0_q   <= '0;
            user0_q <= '0;
            cur0_q  <= '0;
            diff0_q <= '0;
            v1_q    <= 1'b0;
            mk1_q   <= '0;
            user1_q <= '0;
            cur1_q  <= '0;
            diff1_q <= '0;
            mot1_q  <= 1'b0;
            first_q <= 1'b1;
            stat_q  <= 1'b0;
        end else if (cke) begin
            v0_q    <= s_valid;
            mk0_q   <= {s_row_first, s_row_last, s_col_first, s_col_last, s_de};
            user0_q <= s_user;
            cur0_q  <= s_cur;
            diff0_q <= diff0_d;
            v1_q    <= v0_q;
            mk1_q   <= mk0_q;
            user1_q <= user0_q;
            cur1_q  <= cur0_q;
            diff1_q <= (de0 && !first_q) ? diff0_q : '0;
            mot1_q  <= mot_c;
            first_q <= first_q & ~eof;
            stat_q  <= eof;
        end
    end

    assign {m_row_first, m_row_last, m_col_first, m_col_last, m_de} = mk1_q;
    assign m_valid          = v1_q;
    assign m_user           = user1_q;
    assign m_cur            = cur1_q;
    assign m_diff           = diff1_q;
    assign m_motion         = mot1_q;
    assign frame_stat_valid = stat_q;
    assign frame_first      = first_q;

    img_temporal_diff_acc #(.W(SUM_BITS), .IN_W(CH_BITS)) u_sad (
        .clk         (clk),
        .reset       (reset),
        .cke_i       (cke),
        .clear_add_i (sof),
        .add_i       (add),
        .latch_i     (eof),
        .inc_i       (contrib),
        .lat_o       (frame_sad)
    );

    img_temporal_diff_acc #(.W(CNT_BITS), .IN_W(1)) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .cke_i       (cke),
        .clear_add_i (sof),
        .add_i       (add),
        .latch_i     (eof),
        .inc_i       (mot_c),
        .lat_o       (frame_motion_cnt)
    );

`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
    logic [COLS_BITS-1:0] x_q, x_c, mx_x_q, mx_x_d, fx_q;
    logic [ROWS_BITS-1:0] y_q, y_c, mx_y_q, mx_y_d, fy_q;
    logic [CH_BITS-1:0]   mx_q, mx_d, fmax_q;

    // Strict compare keeps the earliest position on ties.
    always_comb begin
        x_c    = mk0_q[2] ? '0 : x_q;
        y_c    = sof ? '0 : y_q;
        mx_d   = mx_q;
        mx_x_d = mx_x_q;
        mx_y_d = mx_y_q;
        if (sof || (add && contrib > mx_q)) begin
            mx_d   = contrib;
            mx_x_d = x_c;
            mx_y_d = y_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            mx_q   <= '0;
            mx_x_q <= '0;
            mx_y_q <= '0;
            fmax_q <= '0;
            fx_q   <= '0;
            fy_q   <= '0;
        end else if (cke) begin
            if (v0_q) begin
                x_q <= de0 ? x_c + COLS_BITS'(1) : x_c;
                y_q <= (de0 && mk0_q[1]) ? y_c + ROWS_BITS'(1) : y_c;
            end
            mx_q   <= mx_d;
            mx_x_q <= mx_x_d;
            mx_y_q <= mx_y_d;
            if (eof) begin
                fmax_q <= mx_d;
                fx_q   <= mx_x_d;
                fy_q   <= mx_y_d;
            end
        end
    end

    assign frame_max_abs = fmax_q;
    assign frame_max_x   = fx_q;
    assign frame_max_y   = fy_q;
`else
    if (COLS_BITS < 1 || ROWS_BITS < 1) begin : g_no_maxpos
    end
`endif
endmodule

// File: tb/tb_img_temporal_diff.sv
// Scoreboard bench for img_temporal_diff: default build plus a narrow-accumulator copy.
module tb_img_temporal_diff;
    localparam int CH = 10;
    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cke = 1'b1;
    logic [CH-1:0] th = '0;
    logic          rf = 0, rl = 0, cf = 0, cl = 0, de = 0, vld = 0;
    logic [CH-1:0] cur = '0, prev = '0;
    logic [0:0]    user = '0;

    logic          m_rf, m_rl, m_cf, m_cl, m_de, m_valid, m_motion;
    logic [0:0]    m_user;
    logic [CH-1:0] m_cur;
    logic [DW-1:0] m_diff;
    logic [31:0]   f_sad;
    logic [19:0]   f_cnt;
    logic          f_sv, f_first;

    logic          z_rf, z_rl, z_cf, z_cl, z_de, z_valid, z_motion;
    logic [0:0]    z_user;
    logic [CH-1:0] z_cur;
    logic [DW-1:0] z_diff;
    logic [11:0]   z_sad;
    logic [2:0]    z_cnt;
    logic          z_sv, z_first;
`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
    logic [CH-1:0] f_mabs, z_mabs;
    logic [9:0]    f_mx, z_mx;
    logic [8:0]    f_my, z_my;
`endif

    img_temporal_diff dut (
        .clk(clk), .reset(reset), .cke(cke), .param_th(th),
        .s_row_first(rf), .s_row_last(rl), .s_col_first(cf), .s_col_last(cl),
        .s_de(de), .s_cur(cur), .s_prev(prev), .s_user(user), .s_valid(vld),
        .m_row_first(m_rf), .m_row_last(m_rl), .m_col_first(m_cf), .m_col_last(m_cl),
        .m_de(m_de), .m_user(m_user), .m_valid(m_valid), .m_cur(m_cur),
        .m_diff(m_diff), .m_motion(m_motion), .frame_sad(f_sad),
        .frame_motion_cnt(f_cnt), .frame_stat_valid(f_sv),
`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
        .frame_max_abs(f_mabs), .frame_max_x(f_mx), .frame_max_y(f_my),
`endif
        .frame_first(f_first)
    );

    img_temporal_diff #(.SUM_BITS(12), .CNT_BITS(3)) dut_s (
        .clk(clk), .reset(reset), .cke(cke), .param_th(th),
        .s_row_first(rf), .s_row_last(rl), .s_col_first(cf), .s_col_last(cl),
        .s_de(de), .s_cur(cur), .s_prev(prev), .s_user(user), .s_valid(vld),
        .m_row_first(z_rf), .m_row_last(z_rl), .m_col_first(z_cf), .m_col_last(z_cl),
        .m_de(z_de), .m_user(z_user), .m_valid(z_valid), .m_cur(z_cur),
        .m_diff(z_diff), .m_motion(z_motion), .frame_sad(z_sad),
        .frame_motion_cnt(z_cnt), .frame_stat_valid(z_sv),
`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
        .frame_max_abs(z_mabs), .frame_max_x(z_mx), .frame_max_y(z_my),
`endif
        .frame_first(z_first)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] data;
        int          stamp;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;
    int     ecyc = 0;
    int     pulses = 0;
    bit     adv = 1'b0;
    bit     stall = 1'b0;
    bit     mfirst = 1'b1;
    longint msad, mcnt, zsad, zcnt, lsad, lcnt, lzsad, lzcnt;
    int     px, py, mx, mxx, mxy, lmx, lmxx, lmxy;

    initial forever begin
        @(posedge clk);
        adv = cke && !reset;
        if (cke && !reset) ecyc++;
    end

    // Output side of the scoreboard; one pop per enabled output beat.
    initial begin : monitor
        exp_t        me;
        logic [27:0] got;
        forever begin
            @(negedge clk);
            if (adv) begin
                if (f_sv) pulses++;
                if (m_valid) begin
                    got = {m_diff, m_motion, m_cur, m_rf, m_rl, m_cf, m_cl, m_de, m_user};
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected got=%h exp=none", got);
                    end else begin
                        me = q.pop_front();
                        if (got !== me.data) begin
                            failures++;
                            $display("FAIL beat got=%h exp=%h", got, me.data);
                        end
                        checks++;
                        if (ecyc - me.stamp !== 1) begin
                            failures++;
                            $display("FAIL latency got=%0d exp=1", ecyc - me.stamp);
                        end
                    end
                    checks++;
                    if ({z_diff, z_motion, z_cur, z_rf, z_rl, z_cf, z_cl, z_de, z_user,
                         z_valid, z_first} !== {got, m_valid, f_first}) begin
                        failures++;
                        $display("FAIL narrow_stream got=%h exp=%h", z_diff, m_diff);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        mfirst = 1'b1;
        msad = 0; mcnt = 0; zsad = 0; zcnt = 0;
        lsad = 0; lcnt = 0; lzsad = 0; lzcnt = 0;
        px = 0; py = 0; mx = 0; mxx = 0; mxy = 0;
        lmx = 0; lmxx = 0; lmxy = 0;
        q.delete();
    endtask

    task automatic beat(input bit b_rf, b_rl, b_cf, b_cl, b_de,
                        input int c, p, input bit u);
        exp_t e;
        int   d, a, ca;
        bit   live, mot;
        if (stall) begin
            cke = 1'b0;
            @(posedge clk); #1;
            cke = 1'b1;
        end
        d    = c - p;
        a    = (d < 0) ? -d : d;
        live = b_de && !mfirst;
        mot  = live && (a > int'(th));
        ca   = live ? a : 0;
        e.data  = {DW'(live ? d : 0), mot, CH'(c), b_rf, b_rl, b_cf, b_cl, b_de, u};
        e.stamp = ecyc + 1;
        if (b_rf && b_cf) begin
            msad = 0; mcnt = 0; zsad = 0; zcnt = 0;
        end
        if (b_de) begin
            msad += ca;
            if (msad > 64'hFFFF_FFFF) msad = 64'hFFFF_FFFF;
            zsad += ca;
            if (zsad > 4095) zsad = 4095;
            mcnt += int'(mot);
            if (mcnt > 20'hFFFFF) mcnt = 20'hFFFFF;
            zcnt += int'(mot);
            if (zcnt > 7) zcnt = 7;
        end
        if (b_cf) px = 0;
        if (b_rf && b_cf) py = 0;
        if ((b_rf && b_cf) || (b_de && ca > mx)) begin
            mx = ca; mxx = px; mxy = py;
        end
        if (b_de) begin
            if (b_cl) py++;
            px++;
        end
        if (b_de && b_rl && b_cl) begin
            lsad = msad; lcnt = mcnt; lzsad = zsad; lzcnt = zcnt;
            lmx = mx; lmxx = mxx; lmxy = mxy;
            mfirst = 1'b0;
        end
        q.push_back(e);
        rf = b_rf; rl = b_rl; cf = b_cf; cl = b_cl; de = b_de; vld = 1'b1;
        cur = CH'(c); prev = CH'(p); user = u;
        @(posedge clk); #1;
        vld = 1'b0; de = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 0; de = 0; rf = 0; rl = 0; cf = 0; cl = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame(input int w, h, c0, p0, step);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                int i;
                i = r * w + k;
                beat(r == 0, r == h - 1, k == 0, k == w - 1, 1'b1,
                     (c0 + step * i) % 1024, p0, i[0]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cke = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_motion, m_diff, m_cur, m_rf, m_rl, m_cf, m_cl, m_de, m_user} !== '0) begin
            failures++;
            $display("FAIL reset_stream got=%b%b%h exp=0", m_valid, m_motion, m_diff);
        end
        checks++;
        if (f_sad !== 32'd0 || f_cnt !== 20'd0 || f_sv !== 1'b0) begin
            failures++;
            $display("FAIL reset_stats got=%0d/%0d/%b exp=0/0/0", f_sad, f_cnt, f_sv);
        end
        checks++;
        if (f_first !== 1'b1) begin
            failures++;
            $display("FAIL reset_first got=%b exp=1", f_first);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_first_frame();
        int p0;
        p0 = pulses; th = 10'd10;
        frame(4, 2, 100, 0, 0);
        idle(4);
        checks++;
        if (f_sad !== 32'd0 || f_cnt !== 20'd0) begin
            failures++;
            $display("FAIL first_stats got=%0d/%0d exp=0/0", f_sad, f_cnt);
        end
        checks++;
        if (pulses - p0 !== 1) begin
            failures++;
            $display("FAIL first_pulse got=%0d exp=1", pulses - p0);
        end
        checks++;
        if (f_first !== 1'b0 || f_sv !== 1'b0) begin
            failures++;
            $display("FAIL first_flag got=%b/%b exp=0/0", f_first, f_sv);
        end
    endtask

    task automatic test_small_diff();
        frame(4, 2, 100, 90, 0);
        idle(4);
        checks++;
        if (f_sad !== 32'd80 || f_cnt !== 20'd0) begin
            failures++;
            $display("FAIL small_stats got=%0d/%0d exp=80/0", f_sad, f_cnt);
        end
    endtask

    task automatic test_max_diff();
        frame(4, 2, 0, 1023, 0);
        idle(4);
        checks++;
        if (f_sad !== 32'd8184 || f_cnt !== 20'd8) begin
            failures++;
            $display("FAIL maxdiff_stats got=%0d/%0d exp=8184/8", f_sad, f_cnt);
        end
        checks++;
        if (z_sad !== 12'd4095 || z_cnt !== 3'd7) begin
            failures++;
            $display("FAIL saturate got=%0d/%0d exp=4095/7", z_sad, z_cnt);
        end
    endtask

    task automatic test_sat_recover();
        frame(4, 2, 500, 500, 0);
        idle(4);
        checks++;
        if (z_sad !== 12'd0 || z_cnt !== 3'd0 || f_sad !== 32'd0) begin
            failures++;
            $display("FAIL sat_recover got=%0d/%0d/%0d exp=0/0/0", z_sad, z_cnt, f_sad);
        end
    endtask

    task automatic test_one_pixel();
        int p0;
        p0 = pulses; th = 10'd3;
        beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8, 3, 1'b0);
        idle(1);
        checks++;
        if (f_sv !== 1'b1) begin
            failures++;
            $display("FAIL one_pulse_on got=%b exp=1", f_sv);
        end
        cke = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (f_sv !== 1'b1) begin
            failures++;
            $display("FAIL pulse_hold got=%b exp=1", f_sv);
        end
        cke = 1'b1;
        idle(1);
        checks++;
        if (f_sv !== 1'b0) begin
            failures++;
            $display("FAIL pulse_drop got=%b exp=0", f_sv);
        end
        idle(3);
        checks++;
        if (f_sad !== 32'd5 || f_cnt !== 20'd1 || pulses - p0 !== 1) begin
            failures++;
            $display("FAIL one_pixel got=%0d/%0d/%0d exp=5/1/1", f_sad, f_cnt, pulses - p0);
        end
    endtask

    task automatic test_cke_stall();
        int p0;
        p0 = pulses; th = 10'd200;
        stall = 1'b1;
        frame(5, 3, 10, 300, 97);
        stall = 1'b0;
        idle(4);
        checks++;
        if (f_sad !== 32'(lsad) || f_cnt !== 20'(lcnt)) begin
            failures++;
            $display("FAIL stall_stats got=%0d/%0d exp=%0d/%0d", f_sad, f_cnt, lsad, lcnt);
        end
        checks++;
        if (z_sad !== 12'(lzsad) || z_cnt !== 3'(lzcnt) || pulses - p0 !== 1) begin
            failures++;
            $display("FAIL stall_narrow got=%0d/%0d/%0d exp=%0d/%0d/1",
                     z_sad, z_cnt, pulses - p0, lzsad, lzcnt);
        end
    endtask

    task automatic test_restart();
        int p0;
        p0 = pulses; th = 10'd2;
        beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 107, 100, 1'b0);
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 107, 100, 1'b1);
        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 103, 100, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 103, 100, 1'b1);
        idle(4);
        checks++;
        if (f_sad !== 32'd6 || f_cnt !== 20'd2 || pulses - p0 !== 1) begin
            failures++;
            $display("FAIL restart got=%0d/%0d/%0d exp=6/2/1", f_sad, f_cnt, pulses - p0);
        end
    endtask

`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
    task automatic test_maxpos();
        th = 10'd1000;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                beat(r == 0, r == 1, k == 0, k == 3, 1'b1,
                     ((k == 1 && r == 0) || (k == 3 && r == 1)) ? 550 : 500, 500, 1'b0);
            end
        end
        idle(4);
        checks++;
        if (f_mabs !== 10'd50 || f_mx !== 10'd1 || f_my !== 9'd0) begin
            failures++;
            $display("FAIL maxpos got=%0d@%0d,%0d exp=50@1,0", f_mabs, f_mx, f_my);
        end
        checks++;
        if (z_mabs !== 10'(lmx) || z_mx !== 10'(lmxx) || z_my !== 9'(lmxy)) begin
            failures++;
            $display("FAIL maxpos_model got=%0d@%0d,%0d exp=%0d@%0d,%0d",
                     z_mabs, z_mx, z_my, lmx, lmxx, lmxy);
        end
    endtask
`endif

    task automatic test_mid_reset();
        th = 10'd10;
        for (int k = 0; k < 4; k++)
            beat(1'b1, 1'b0, k == 0, k == 3, 1'b1, 200, 100, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        checks++;
        if (m_valid !== 1'b0 || m_diff !== '0 || f_sad !== 32'd0 || f_sv !== 1'b0) begin
            failures++;
            $display("FAIL midreset_out got=%b/%h/%0d/%b exp=0/0/0/0", m_valid, m_diff, f_sad, f_sv);
        end
        checks++;
        if (f_first !== 1'b1) begin
            failures++;
            $display("FAIL midreset_first got=%b exp=1", f_first);
        end
        frame(4, 2, 200, 100, 0);
        idle(4);
        checks++;
        if (f_sad !== 32'd0 || f_cnt !== 20'd0 || f_first !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_suppress got=%0d/%0d/%b exp=0/0/0", f_sad, f_cnt, f_first);
        end
        frame(4, 2, 200, 100, 0);
        idle(4);
        checks++;
        if (f_sad !== 32'd800 || f_cnt !== 20'd8) begin
            failures++;
            $display("FAIL post_reset_frame got=%0d/%0d exp=800/8", f_sad, f_cnt);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_small_diff();
        test_max_diff();
        test_sat_recover();
        test_one_pixel();
        test_cke_stall();
        test_restart();
`ifdef IMG_TEMPORAL_DIFF_MAXPOS_EN
        test_maxpos();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
